adc_capture: RTL and testbench
==============================

# adc_capture

Serial audio receiver for the codec ADC path: deserializes `AUD_ADCDAT` in I2S format using the codec-driven `AUD_BCLK` / `AUD_ADCLRCK`, all oversampled in the `CLOCK_50` domain. It delivers one left/right 16-bit sample pair per frame over a valid/ready handshake. It sits beside the DAC-side audio path in the synth top and feeds the Nios II / effects logic with captured input audio.

## Interface
- `DATA_W`, 16: bits captured per channel, MSB first.
- `Clk` in 1: system clock (`CLOCK_50`); the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `AUD_BCLK` in 1: codec bit clock, asynchronous to `Clk`.
- `AUD_ADCLRCK` in 1: codec ADC word clock, asynchronous; low = left, high = right.
- `AUD_ADCDAT` in 1: codec serial ADC data, asynchronous.
- `enable` in 1: capture enable; when low, the FSM holds in IDLE.
- `LDATA_IN` out DATA_W: last complete left sample, two's complement.
- `RDATA_IN` out DATA_W: last complete right sample.
- `sample_valid` out 1: pair available.
- `sample_ready` in 1: consumer accepts pair.
- `overrun` out 1: sticky; a frame was dropped.
- `overrun_clr` in 1: clears `overrun`.
- `frame_err` out 1: one-cycle pulse; a channel was truncated.
- `peak` out DATA_W: only with `ADC_PEAK_EN`; absolute peak hold.

## Operation
- Synchronize `AUD_BCLK`, `AUD_ADCLRCK` and `AUD_ADCDAT` through 2 flops each, then register once more for edge detection.
- BCLK rise = sync==1 && prev==0. Sample LRCK and DAT only on BCLK rise.
- LRCK edge = LRCK value at the current BCLK rise differs from its value at the previous BCLK rise.
- FSM states:
  - IDLE: wait for `enable` and an LRCK edge; go to SKIP.
  - SKIP: consume the one I2S delay bit; go to SHIFT.
  - SHIFT: shift DAT into `shreg` MSB first and increment `bitcnt`.
    - At `bitcnt==DATA_W-1`, store `shreg` into the left or right hold register per LRCK and go to WAIT.
    - If an LRCK edge occurs first: pulse `frame_err`, discard the partial word, go to SKIP.
  - WAIT: ignore extra bits. On an LRCK edge go to SKIP. If `enable` is low go to IDLE.
- Pair completion: the right word completes and a left word was captured in the same frame.
  - If `sample_valid==0`: load `LDATA_IN`/`RDATA_IN` and set `sample_valid`.
  - If `sample_valid==1` and `sample_ready==0` in that cycle: keep the old pair, set `overrun`.
  - If `sample_valid==1` and `sample_ready==1` in the same cycle: load the new pair; `sample_valid` stays 1; no overrun.
- `sample_valid` clears on `sample_ready` when no new pair completes that cycle.
- `overrun` set and `overrun_clr` in the same cycle: set wins.
- Reset state:
  - FSM is IDLE; `shreg` and `bitcnt` are 0.
  - `LDATA_IN`, `RDATA_IN`, `peak` are 0.
  - `sample_valid`, `overrun`, `frame_err` are 0.
- Reset mid-frame: capture restarts at the next LRCK edge; the partial frame is discarded with no `frame_err`.

## Timing
- Pad-to-edge detection latency: 3 `Clk` cycles.
- `sample_valid` rises 1 `Clk` cycle after the BCLK rise that samples the right channel LSB.
- Required clock ratio: `Clk` ≥ 6× BCLK frequency, with each BCLK phase ≥ 3 `Clk` periods.
- Sample rate: one pair per LRCK period. The consumer must assert `sample_ready` within one frame to avoid overrun.
- `frame_err` is exactly 1 cycle wide, issued in the cycle after the offending LRCK edge detection.

## Configuration
- `ADC_PEAK_EN` defined:
  - `peak` tracks max(|L|, |R|) over all accepted pairs.
  - |−32768| saturates to 0x7FFF.
  - `peak` clears to 0 on `overrun_clr`.
- Not defined: `peak` port and its logic are absent; all other behaviour is identical.

## Test plan
- Basic capture: BCLK = Clk/16, I2S frame with L=0x1234 and R=0xA5A5, 32 bits per channel → `sample_valid` rises with `LDATA_IN`=0x1234 and `RDATA_IN`=0xA5A5. Extra bits ignored. `ready` pulse clears `valid`.
- Backpressure: hold `sample_ready`=0 across 2 frames (0x0001/0x0002 then 0x0003/0x0004) → outputs stay 0x0001/0x0002 and `overrun`=1. `overrun_clr` → `overrun`=0.
- Simultaneous accept: assert `sample_ready` in the exact cycle a new pair completes → new pair loaded, `sample_valid` stays 1, `overrun`=0.
- Truncation: LRCK toggles after 10 right-channel bits → one `frame_err` pulse. No `sample_valid`; the next full frame captures correctly.
- Reset mid-frame: drive `Reset_n` low during left bit 7 → all outputs 0 immediately. The first complete frame after release is captured correctly.
- Peak (`ADC_PEAK_EN`): pairs (0x0100,0xFF00) then (0x8000,0x0001) → `peak` = 0x0100, then 0x7FFF.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: I2S ADC receiver; oversamples AUD_BCLK/AUD_ADCLRCK/AUD_ADCDAT in Clk and emits L/R pairs.
// Latency: pad-to-edge 3 Clk; sample_valid rises 1 Clk after the BCLK rise that samples the right LSB.
// Backpressure: valid/ready; a pair completing while the previous one is still unaccepted is dropped and
// sets sticky overrun. Optional ADC_PEAK_EN adds the peak output (absolute peak hold over accepted pairs).
module adc_capture #(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              AUD_BCLK,
  input  logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  input  logic              enable,
  output logic [DATA_W-1:0] LDATA_IN,
  output logic [DATA_W-1:0] RDATA_IN,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              frame_err
`ifdef ADC_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_WAIT} state_t;

  // Synchronizer stages; bclk gets one extra stage for rise detection.
  logic bclk_meta_q, bclk_sync_q, bclk_prev_q;
  logic lrck_meta_q, lrck_sync_q;
  logic dat_meta_q, dat_sync_q;

  // LRCK as seen at the previous BCLK rise; init flag suppresses a false edge after reset.
  logic lrck_last_q, lrck_init_q;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [DATA_W-1:0] lhold_q;
  logic              left_ok_q;
  logic              frame_err_q;

  logic [DATA_W-1:0] ldata_q, rdata_q;
  logic              valid_q, overrun_q;

  logic bclk_rise, lrck_edge, last_bit, pair_done, load_pair;

  assign bclk_rise = bclk_sync_q & ~bclk_prev_q;
  assign lrck_edge = bclk_rise & lrck_init_q & (lrck_sync_q != lrck_last_q);
  assign last_bit  = (bitcnt_q == LAST_BIT);

  // The right word completes on this BCLK rise and a left word of the same frame is held.
  assign pair_done = enable & (state_q == S_SHIFT) & bclk_rise & ~lrck_edge & last_bit
                   & lrck_sync_q & left_ok_q;
  assign load_pair = pair_done & (~valid_q | sample_ready);

  // Next shift-register value: MSB-first shift of the current data bit.
  always_comb begin
    shreg_d = {shreg_q[DATA_W-2:0], dat_sync_q};
  end

  // Two-flop synchronizers for the codec pins plus the BCLK edge-detect stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bclk_meta_q <= 1'b0;
      bclk_sync_q <= 1'b0;
      bclk_prev_q <= 1'b0;
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      dat_meta_q  <= 1'b0;
      dat_sync_q  <= 1'b0;
    end else begin
      bclk_meta_q <= AUD_BCLK;
      bclk_sync_q <= bclk_meta_q;
      bclk_prev_q <= bclk_sync_q;
      lrck_meta_q <= AUD_ADCLRCK;
      lrck_sync_q <= lrck_meta_q;
      dat_meta_q  <= AUD_ADCDAT;
      dat_sync_q  <= dat_meta_q;
    end
  end

  // Track LRCK at each BCLK rise; the first rise after reset only records a reference.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lrck_last_q <= 1'b0;
      lrck_init_q <= 1'b0;
    end else if (bclk_rise) begin
      lrck_last_q <= lrck_sync_q;
      lrck_init_q <= 1'b1;
    end
  end

  // Capture FSM: frame alignment, word shifting, left hold and truncation detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      lhold_q     <= '0;
      left_ok_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (!enable) begin
        state_q   <= S_IDLE;
        shreg_q   <= '0;
        bitcnt_q  <= '0;
        left_ok_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (lrck_edge) begin
              state_q   <= S_SKIP;
              left_ok_q <= 1'b0;
            end
          end
          // The BCLK rise that revealed the LRCK edge carried the I2S delay bit; start fresh.
          S_SKIP: begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            state_q  <= S_SHIFT;
          end
          S_SHIFT: begin
            if (bclk_rise) begin
              if (lrck_edge) begin
                frame_err_q <= 1'b1;
                left_ok_q   <= 1'b0;
                shreg_q     <= '0;
                bitcnt_q    <= '0;
                state_q     <= S_SKIP;
              end else begin
                shreg_q <= shreg_d;
                if (last_bit) begin
                  bitcnt_q <= '0;
                  state_q  <= S_WAIT;
                  if (!lrck_sync_q) begin
                    lhold_q   <= shreg_d;
                    left_ok_q <= 1'b1;
                  end else begin
                    left_ok_q <= 1'b0;
                  end
                end else begin
                  bitcnt_q <= bitcnt_q + 1'b1;
                end
              end
            end
          end
          S_WAIT: begin
            if (lrck_edge) begin
              state_q <= S_SKIP;
              // A transition to left starts a new frame; any stale left word is void.
              if (!lrck_sync_q) left_ok_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Output pair register with valid/ready handshake and sticky overrun.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ldata_q   <= '0;
      rdata_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_pair) begin
        ldata_q <= lhold_q;
        rdata_q <= shreg_d;
        valid_q <= 1'b1;
      end else if (sample_ready) begin
        valid_q <= 1'b0;
      end
      if (pair_done && valid_q && !sample_ready) overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
    end
  end

`ifdef ADC_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_base, mag_l, mag_r, peak_d;

  // Magnitude with the most negative code saturated to the largest positive code.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x);
    if (!x[DATA_W-1]) return x;
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    return -x;
  endfunction

  // Running max of the held peak (or zero when clearing) and both new magnitudes.
  always_comb begin
    peak_base = overrun_clr ? '0 : peak_q;
    mag_l     = mag(lhold_q);
    mag_r     = mag(shreg_d);
    peak_d    = peak_base;
    if (mag_l > peak_d) peak_d = mag_l;
    if (mag_r > peak_d) peak_d = mag_r;
  end

  // Peak hold updates only on accepted pairs; overrun_clr restarts it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      peak_q <= '0;
    end else if (load_pair) begin
      peak_q <= peak_d;
    end else if (overrun_clr) begin
      peak_q <= '0;
    end
  end

  assign peak = peak_q;
`endif

  assign LDATA_IN     = ldata_q;
  assign RDATA_IN     = rdata_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: directed I2S frames into adc_capture with a queue of expected L/R pairs.
// BCLK = Clk/16; pads driven on Clk negedges, outputs sampled on negedges.
// Covers reset, capture, backpressure/overrun, same-cycle accept, truncation, mid-frame reset, peak.
module tb_adc_capture;

  localparam int W    = 16;
  localparam int HALF = 8;   // Clk cycles per BCLK phase

  logic         Clk, Reset_n;
  logic         AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, enable;
  logic [W-1:0] LDATA_IN, RDATA_IN;
  logic         sample_valid, sample_ready, overrun, overrun_clr, frame_err;
`ifdef ADC_PEAK_EN
  logic [W-1:0] peak;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  logic [31:0] exp_q[$];

  adc_capture #(.DATA_W(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
    .enable(enable),
    .LDATA_IN(LDATA_IN), .RDATA_IN(RDATA_IN),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .frame_err(frame_err)
`ifdef ADC_PEAK_EN
    , .peak(peak)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count cycles in which frame_err is high; one pulse must contribute exactly one.
  always @(negedge Clk) if (frame_err === 1'b1) ferr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One I2S channel: slot 0 is the delay bit, slots 1..W carry MSB..LSB, rest padding.
  // acc_slot: pulse sample_ready in the Clk cycle the DUT acts on that slot's BCLK rise.
  // rst_slot: pulse Reset_n low shortly after that slot's BCLK rise and check outputs.
  task automatic send_channel(input logic lr, input logic [W-1:0] word, input int nslots,
                              input int acc_slot, input int rst_slot);
    for (int i = 0; i < nslots; i++) begin
      @(negedge Clk);
      AUD_BCLK    = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT  = (i >= 1 && i <= W) ? word[W-i] : 1'b0;
      repeat (HALF - 1) @(negedge Clk);
      @(negedge Clk);
      AUD_BCLK = 1'b1;
      if (i == acc_slot) begin
        repeat (2) @(negedge Clk);
        sample_ready = 1'b1;
        @(negedge Clk);
        sample_ready = 1'b0;
        repeat (HALF - 4) @(negedge Clk);
      end else if (i == rst_slot) begin
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_L", LDATA_IN, 0);
        chk("rst_mid_R", RDATA_IN, 0);
        chk("rst_mid_valid", sample_valid, 0);
        chk("rst_mid_overrun", overrun, 0);
        chk("rst_mid_frame_err", frame_err, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (HALF - 3) @(negedge Clk);
      end else begin
        repeat (HALF - 1) @(negedge Clk);
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
    send_channel(1'b0, l, 32, -1, -1);
    send_channel(1'b1, r, 32, -1, -1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (sample_valid === 1'b1) break;
      @(negedge Clk);
    end
    chk(tag, sample_valid, 1);
  endtask

  task automatic check_pair(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty queue expected a pending pair", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_L"}, LDATA_IN, e[31:16]);
      chk({tag, "_R"}, RDATA_IN, e[15:0]);
    end
  endtask

  task automatic ready_pulse();
    @(negedge Clk);
    sample_ready = 1'b1;
    @(negedge Clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    Reset_n      = 1'b0;
    AUD_BCLK     = 1'b0;
    AUD_ADCLRCK  = 1'b0;
    AUD_ADCDAT   = 1'b0;
    enable       = 1'b0;
    sample_ready = 1'b0;
    overrun_clr  = 1'b0;
    repeat (3) @(negedge Clk);

    chk("reset_L", LDATA_IN, 0);
    chk("reset_R", RDATA_IN, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_err", frame_err, 0);
`ifdef ADC_PEAK_EN
    chk("reset_peak", peak, 0);
`endif
    Reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(negedge Clk);

    // Lead-in right channel so the first real frame starts on a clean left edge.
    send_channel(1'b1, 16'h0000, 32, -1, -1);

    // Basic capture, 32 slots per channel; extra bits ignored.
    exp_q.push_back({16'h1234, 16'hA5A5});
    send_frame(16'h1234, 16'hA5A5);
    wait_valid("basic_valid");
    check_pair("basic");
    chk("basic_overrun", overrun, 0);
    chk("basic_frame_err_cnt", ferr_cnt, 0);
    ready_pulse();
    chk("basic_ready_clears", sample_valid, 0);

    // Backpressure across two frames: second pair dropped, overrun sticky.
    exp_q.push_back({16'h0001, 16'h0002});
    send_frame(16'h0001, 16'h0002);
    send_frame(16'h0003, 16'h0004);
    chk("bp_valid", sample_valid, 1);
    check_pair("bp");
    chk("bp_overrun", overrun, 1);
    @(negedge Clk);
    overrun_clr = 1'b1;
    @(negedge Clk);
    overrun_clr = 1'b0;
    chk("bp_overrun_clr", overrun, 0);

    // Same-cycle accept: ready lands exactly when the new pair completes.
    exp_q.push_back({16'h0005, 16'h0006});
    send_channel(1'b0, 16'h0005, 32, -1, -1);
    send_channel(1'b1, 16'h0006, 32, W, -1);
    chk("acc_valid", sample_valid, 1);
    check_pair("acc");
    chk("acc_overrun", overrun, 0);
    ready_pulse();
    chk("acc_ready_clears", sample_valid, 0);

    // Truncation: right channel cut after 10 bits, then a full frame.
    send_channel(1'b0, 16'h1111, 32, -1, -1);
    send_channel(1'b1, 16'h2222, 11, -1, -1);
    exp_q.push_back({16'h7777, 16'h0888});
    send_frame(16'h7777, 16'h0888);
    chk("trunc_frame_err_cnt", ferr_cnt, 1);
    wait_valid("trunc_next_valid");
    check_pair("trunc_next");

    // Build valid=1 and overrun=1, then reset during left bit 7.
    send_frame(16'h0009, 16'h000A);
    chk("pre_rst_overrun", overrun, 1);
    send_channel(1'b0, 16'hFFFF, 32, -1, W - 7);
    send_channel(1'b1, 16'hFFFF, 32, -1, -1);
    chk("post_rst_no_valid", sample_valid, 0);
    exp_q.push_back({16'h4321, 16'h8765});
    send_frame(16'h4321, 16'h8765);
    wait_valid("post_rst_valid");
    check_pair("post_rst");
    chk("post_rst_overrun", overrun, 0);
    chk("post_rst_frame_err_cnt", ferr_cnt, 1);
    ready_pulse();

`ifdef ADC_PEAK_EN
    chk("peak_after_reset_pair", peak, 16'h789B);
    @(negedge Clk);
    overrun_clr = 1'b1;
    @(negedge Clk);
    overrun_clr = 1'b0;
    chk("peak_clr", peak, 0);
    exp_q.push_back({16'h0100, 16'hFF00});
    send_frame(16'h0100, 16'hFF00);
    wait_valid("peak1_valid");
    check_pair("peak1");
    chk("peak1", peak, 16'h0100);
    ready_pulse();
    exp_q.push_back({16'h8000, 16'h0001});
    send_frame(16'h8000, 16'h0001);
    wait_valid("peak2_valid");
    check_pair("peak2");
    chk("peak2_sat", peak, 16'h7FFF);
    ready_pulse();
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
